// File: rtl/instr_fetch.sv
// ============================================================================
// Module   : instr_fetch
// Brief    : Instruction fetch unit with a one-cycle ROM prime, a one-bubble
//            redirect squash and halt/restart control. Defining FETCH_TRACE_EN
//            adds a saturating valid-instruction counter on Instr_Count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module instr_fetch #(
    parameter int          PC_W     = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Jmp_Flag,
    input  logic            Beq_Flag,
    input  logic            Branch_Taken,
    input  logic [PC_W-1:0] Target,
    input  logic            Halt,
    output logic [PC_W-1:0] Rom_Addr,
    input  logic [8:0]      Rom_Data,
    output logic [8:0]      Instruction,
    output logic            Instr_Valid,
    output logic [PC_W-1:0] Instr_PC,
`ifdef FETCH_TRACE_EN
    output logic [15:0]     Instr_Count,
`endif
    output logic            Done
);

    localparam logic [PC_W-1:0] c_RESET_PC = PC_W'(RESET_PC);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_HALTED = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_instr_pc;
    logic            r_valid;
    logic            r_done;

    logic            w_run;
    logic            w_start_acc;
    logic            w_halt;
    logic            w_redirect;

    // State register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:   if (Start) w_state_nxt = c_RUN;
            c_RUN:    if (w_halt) w_state_nxt = c_HALTED;
            c_HALTED: if (Start) w_state_nxt = c_RUN;
            default:  w_state_nxt = c_IDLE;
        endcase
    end

    // Control decode; halt outranks any same-cycle jump or branch
    always_comb begin
        w_run       = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            c_RUN:    w_run = 1'b1;
            c_IDLE,
            c_HALTED: w_start_acc = Start;
            default:  w_start_acc = 1'b0;
        endcase
        w_halt     = w_run && r_valid && Halt;
        w_redirect = w_run && r_valid && !Halt &&
                     (Jmp_Flag || (Beq_Flag && Branch_Taken));
    end

    // Fetch datapath: the word fetched during a redirect is wrong-path and
    // is squashed by dropping valid for exactly one cycle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc       <= c_RESET_PC;
            r_instr_pc <= c_RESET_PC;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else if (w_start_acc) begin
            r_pc    <= c_RESET_PC;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_halt) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
        end else if (w_run) begin
            r_instr_pc <= r_pc;
            r_pc       <= w_redirect ? Target : r_pc + PC_W'(1);
            r_valid    <= !w_redirect;
        end
    end

`ifdef FETCH_TRACE_EN
    logic [15:0] r_count;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_count <= '0;
        end else if (w_start_acc) begin
            r_count <= '0;
        end else if (r_valid && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign Instr_Count = r_count;
`endif

    assign Rom_Addr    = r_pc;
    assign Instr_PC    = r_instr_pc;
    assign Instr_Valid = r_valid;
    assign Instruction = r_valid ? Rom_Data : 9'h000;
    assign Done        = r_done;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch (PC_W=10 and PC_W=4).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Start = 1'b0;
    logic       Jmp_Flag = 1'b0;
    logic       Beq_Flag = 1'b0;
    logic       Branch_Taken = 1'b0;
    logic [9:0] Target = '0;
    logic       Halt = 1'b0;
    logic [9:0] Rom_Addr;
    logic [8:0] Rom_Data = '0;
    logic [8:0] Instruction;
    logic       Instr_Valid;
    logic [9:0] Instr_PC;
    logic       Done;

    logic       Start4 = 1'b0;
    logic [3:0] Rom_Addr4;
    logic [8:0] Rom_Data4 = '0;
    logic [8:0] Instruction4;
    logic       Instr_Valid4;
    logic [3:0] Instr_PC4;
    logic       Done4;
`ifdef FETCH_TRACE_EN
    logic [15:0] Instr_Count;
    logic [15:0] Instr_Count4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    function automatic logic [8:0] romval(input int a);
        return 9'((a + 1) * 16);
    endfunction

    always @(posedge Clk) Rom_Data  <= romval(int'(Rom_Addr));
    always @(posedge Clk) Rom_Data4 <= romval(int'(Rom_Addr4));

    instr_fetch #(.PC_W(10), .RESET_PC(0)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Jmp_Flag(Jmp_Flag),
        .Beq_Flag(Beq_Flag), .Branch_Taken(Branch_Taken), .Target(Target),
        .Halt(Halt), .Rom_Addr(Rom_Addr), .Rom_Data(Rom_Data),
        .Instruction(Instruction), .Instr_Valid(Instr_Valid),
        .Instr_PC(Instr_PC),
`ifdef FETCH_TRACE_EN
        .Instr_Count(Instr_Count),
`endif
        .Done(Done)
    );

    instr_fetch #(.PC_W(4), .RESET_PC(0)) dut4 (
        .Clk(Clk), .Reset(Reset), .Start(Start4), .Jmp_Flag(1'b0),
        .Beq_Flag(1'b0), .Branch_Taken(1'b0), .Target(4'd0),
        .Halt(1'b0), .Rom_Addr(Rom_Addr4), .Rom_Data(Rom_Data4),
        .Instruction(Instruction4), .Instr_Valid(Instr_Valid4),
        .Instr_PC(Instr_PC4),
`ifdef FETCH_TRACE_EN
        .Instr_Count(Instr_Count4),
`endif
        .Done(Done4)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if (Instr_Valid !== 1'b0 || Done !== 1'b0 || Rom_Addr !== 10'd0 ||
            Instr_PC !== 10'd0 || Instruction !== 9'h000) begin
            errors++;
            $display("FAIL reset_state: valid=%b done=%b addr=%0d ipc=%0d instr=%h exp 0 0 0 0 000",
                     Instr_Valid, Done, Rom_Addr, Instr_PC, Instruction);
        end
        Reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (Instr_Valid !== 1'b0 || Rom_Addr !== 10'd0 || Done !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: valid=%b addr=%0d done=%b exp 0 0 0",
                     Instr_Valid, Rom_Addr, Done);
        end
    endtask

    task automatic test_straight();
        do_start();
        checks++;
        if (Instr_Valid !== 1'b0 || Rom_Addr !== 10'd0) begin
            errors++;
            $display("FAIL prime_cycle: valid=%b addr=%0d exp 0 0", Instr_Valid, Rom_Addr);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (Instr_Valid !== 1'b1 || Instr_PC !== 10'(i) || Instruction !== romval(i)) begin
                errors++;
                $display("FAIL straight_%0d: valid=%b ipc=%0d instr=%h exp 1 %0d %h",
                         i, Instr_Valid, Instr_PC, Instruction, i, romval(i));
            end
        end
    endtask

    task automatic test_branch();
        Beq_Flag = 1'b1; Branch_Taken = 1'b0; Target = 10'd3;
        tick();
        Beq_Flag = 1'b0;
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 10'd8) begin
            errors++;
            $display("FAIL beq_not_taken: valid=%b ipc=%0d exp 1 8", Instr_Valid, Instr_PC);
        end
        Beq_Flag = 1'b1; Branch_Taken = 1'b1; Target = 10'd3;
        tick();
        Beq_Flag = 1'b0; Branch_Taken = 1'b0;
        checks++;
        if (Instr_Valid !== 1'b0 || Instruction !== 9'h000) begin
            errors++;
            $display("FAIL beq_bubble: valid=%b instr=%h exp 0 000", Instr_Valid, Instruction);
        end
        tick();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 10'd3 || Instruction !== 9'h040) begin
            errors++;
            $display("FAIL beq_target: valid=%b ipc=%0d instr=%h exp 1 3 040",
                     Instr_Valid, Instr_PC, Instruction);
        end
    endtask

    task automatic test_jump();
        do_reset();
        do_start();
        repeat (3) tick();
        checks++;
        if (Instr_PC !== 10'd2 || Instr_Valid !== 1'b1) begin
            errors++;
            $display("FAIL jump_setup: ipc=%0d valid=%b exp 2 1", Instr_PC, Instr_Valid);
        end
        Jmp_Flag = 1'b1; Target = 10'd40;
        tick();
        // Flags during the bubble must be ignored
        Target = 10'd50;
        checks++;
        if (Instr_Valid !== 1'b0) begin
            errors++;
            $display("FAIL jump_bubble: valid=%b exp 0", Instr_Valid);
        end
        tick();
        Jmp_Flag = 1'b0;
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 10'd40 || Instruction !== 9'h090) begin
            errors++;
            $display("FAIL jump_target: valid=%b ipc=%0d instr=%h exp 1 40 090",
                     Instr_Valid, Instr_PC, Instruction);
        end
        tick();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 10'd41) begin
            errors++;
            $display("FAIL jump_next: valid=%b ipc=%0d exp 1 41", Instr_Valid, Instr_PC);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        do_start();
        repeat (5) tick();
        checks++;
        if (Rom_Addr !== 10'd5 || Instr_Valid !== 1'b1) begin
            errors++;
            $display("FAIL midrun_setup: addr=%0d valid=%b exp 5 1", Rom_Addr, Instr_Valid);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (Instr_Valid !== 1'b0 || Rom_Addr !== 10'd0 || Done !== 1'b0 ||
            Instr_PC !== 10'd0 || Instruction !== 9'h000) begin
            errors++;
            $display("FAIL midrun_reset: valid=%b addr=%0d done=%b ipc=%0d instr=%h exp 0 0 0 0 000",
                     Instr_Valid, Rom_Addr, Done, Instr_PC, Instruction);
        end
        tick();
        Reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (Instr_Valid !== 1'b0 || Rom_Addr !== 10'd0) begin
            errors++;
            $display("FAIL midrun_idle: valid=%b addr=%0d exp 0 0", Instr_Valid, Rom_Addr);
        end
    endtask

    task automatic test_halt();
        do_reset();
        do_start();
        repeat (4) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 10'd4) begin
            errors++;
            $display("FAIL start_in_run: valid=%b ipc=%0d exp 1 4", Instr_Valid, Instr_PC);
        end
        repeat (5) tick();
        Halt = 1'b1; Jmp_Flag = 1'b1; Target = 10'd20;
        tick();
        Halt = 1'b0; Jmp_Flag = 1'b0;
        checks++;
        if (Done !== 1'b1 || Instr_Valid !== 1'b0 || Instr_PC !== 10'd9 || Rom_Addr !== 10'd10) begin
            errors++;
            $display("FAIL halt_entry: done=%b valid=%b ipc=%0d addr=%0d exp 1 0 9 10",
                     Done, Instr_Valid, Instr_PC, Rom_Addr);
        end
        repeat (3) tick();
        checks++;
        if (Done !== 1'b1 || Instr_Valid !== 1'b0 || Instr_PC !== 10'd9 || Rom_Addr !== 10'd10) begin
            errors++;
            $display("FAIL halt_hold: done=%b valid=%b ipc=%0d addr=%0d exp 1 0 9 10",
                     Done, Instr_Valid, Instr_PC, Rom_Addr);
        end
        do_start();
        checks++;
        if (Done !== 1'b0 || Instr_Valid !== 1'b0 || Rom_Addr !== 10'd0) begin
            errors++;
            $display("FAIL restart: done=%b valid=%b addr=%0d exp 0 0 0", Done, Instr_Valid, Rom_Addr);
        end
        tick();
        checks++;
        if (Instr_Valid !== 1'b1 || Instr_PC !== 10'd0 || Instruction !== 9'h010) begin
            errors++;
            $display("FAIL restart_fetch: valid=%b ipc=%0d instr=%h exp 1 0 010",
                     Instr_Valid, Instr_PC, Instruction);
        end
    endtask

    task automatic test_wrap();
        Start4 = 1'b1;
        tick();
        Start4 = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (Instr_Valid4 !== 1'b1 || Instr_PC4 !== 4'(i) || Instruction4 !== romval(i)) begin
                errors++;
                $display("FAIL wrap_%0d: valid=%b ipc=%0d instr=%h exp 1 %0d %h",
                         i, Instr_Valid4, Instr_PC4, Instruction4, i, romval(i));
            end
            tick();
        end
        checks++;
        if (Instr_Valid4 !== 1'b1 || Instr_PC4 !== 4'd0 || Instruction4 !== 9'h010) begin
            errors++;
            $display("FAIL wrap_zero: valid=%b ipc=%0d instr=%h exp 1 0 010",
                     Instr_Valid4, Instr_PC4, Instruction4);
        end
        tick();
`ifdef FETCH_TRACE_EN
        checks++;
        if (Instr_Count4 !== 16'd17) begin
            errors++;
            $display("FAIL trace_count: got %0d exp 17", Instr_Count4);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_straight();
        test_branch();
        test_jump();
        test_reset_midrun();
        test_halt();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter PC_W, default 10, meaning the program counter width in bits.
REQ-002 The block SHALL have parameter RESET_PC, default 0, meaning the first fetch address after Start.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port Start, input, 1 bit: begin program execution; sampled only in IDLE or HALTED.
REQ-006 The block SHALL have port Jmp_Flag, input, 1 bit: unconditional jump request from the control decoder.
REQ-007 The block SHALL have port Beq_Flag, input, 1 bit: conditional branch request from the control decoder.
REQ-008 The block SHALL have port Branch_Taken, input, 1 bit: branch condition result, qualifying Beq_Flag.
REQ-009 The block SHALL have port Target, input, PC_W bits: jump/branch destination from the target LUT.
REQ-010 The block SHALL have port Halt, input, 1 bit: program-complete (Ack) from the control decoder.
REQ-011 The block SHALL have port Rom_Addr, output, PC_W bits: instruction ROM address, equal to the fetch PC register.
REQ-012 The block SHALL have port Rom_Data, input, 9 bits: instruction ROM read data, one cycle after Rom_Addr (registered ROM).
REQ-013 The block SHALL have port Instruction, output, 9 bits: instruction to the control decoder; Rom_Data when Instr_Valid=1, else 9'h000.
REQ-014 The block SHALL have port Instr_Valid, output, 1 bit: Instruction is architecturally live this cycle.
REQ-015 The block SHALL have port Instr_PC, output, PC_W bits: address of the instruction on Instruction.
REQ-016 The block SHALL have port Done, output, 1 bit: program has halted.

Function
REQ-017 The block SHALL implement states IDLE, RUN, HALTED; IDLE->RUN and HALTED->RUN on Start=1; RUN->HALTED on Instr_Valid=1 and Halt=1; Start in RUN is ignored.
REQ-018 On Start acceptance, the block SHALL load fetch PC=RESET_PC, clear Done, and hold Instr_Valid=0 for the first RUN cycle (ROM prime); the first valid instruction appears 2 cycles after the Start edge.
REQ-019 Each RUN cycle, the block SHALL set Instr_PC<=fetch PC, fetch PC<=fetch PC+1 modulo 2^PC_W (2^PC_W-1 wraps to 0), and Instr_Valid<=1 unless squashed.
REQ-020 Redirect SHALL occur when Instr_Valid=1 and (Jmp_Flag=1 or (Beq_Flag=1 and Branch_Taken=1)): fetch PC<=Target and next-cycle Instr_Valid<=0 (one-bubble squash of the wrong-path word).
REQ-021 Flags SHALL be ignored when Instr_Valid=0; Beq_Flag with Branch_Taken=0 SHALL not redirect.
REQ-022 Halt SHALL take priority over Jmp/Beq in the same cycle; Jmp and Beq together SHALL use Target once.
REQ-023 On halt, the block SHALL drive Instr_Valid<=0 and Done<=1 next cycle, freeze fetch PC and Instr_PC, and hold Done=1 until Start.

Reset
REQ-024 Reset low SHALL immediately force state IDLE, fetch PC=RESET_PC, Instr_PC=RESET_PC, Instr_Valid=0, Done=0, Instruction=9'h000, and trace count 0 when present, including mid-RUN or mid-squash.
REQ-025 After Reset deasserts, the block SHALL remain in IDLE until Start=1.

Configuration
REQ-026 With macro FETCH_TRACE_EN defined, the block SHALL add output Instr_Count (16 bits), counting cycles with Instr_Valid=1, saturating at 16'hFFFF, cleared on Start acceptance and reset.
REQ-027 Without FETCH_TRACE_EN, Instr_Count and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-028 Reset low mid-RUN at fetch PC=5 -> same cycle Instr_Valid=0, Rom_Addr=0, Done=0; IDLE until Start.
REQ-029 ROM[0..3]=9'h010,9'h020,9'h030,9'h040; Start at cycle 0 -> Instr_Valid=1 from cycle 2, Instr_PC 0,1,2,3 with matching Instruction.
REQ-030 Jmp_Flag=1, Target=40 while Instr_PC=2 -> next cycle Instr_Valid=0, then Instr_PC=40.
REQ-031 Beq_Flag=1 with Branch_Taken=0 at Instr_PC=7 -> no bubble, Instr_PC=8; Branch_Taken=1, Target=3 -> bubble, then Instr_PC=3.
REQ-032 Halt=1 and Jmp_Flag=1 together at Instr_PC=9 -> Done=1, Instr_Valid=0 held; Start -> Done=0, refetch from RESET_PC.
REQ-033 PC_W=4, straight-line code through 15 -> Instr_PC 15 then 0, no bubble; with FETCH_TRACE_EN, Instr_Count=17 after 17 valid cycles.
